fir_coeff_ctrl: RTL

Coefficient controller for the 21-tap FIR datapath. Accepts a new coefficient set over a valid/ready stream into a shadow bank. On a commit request it swaps the shadow bank with the active bank, exactly at a sample boundary, so no FIR output ever mixes taps from two sets. It sits beside the FIR `top`, driving its flat coefficient bus; sample flow is unchanged.

---
 rtl/fir_ctrl_pkg.sv | 27 ++
 rtl/fir_coeff_bank.sv | 58 +++++
 rtl/fir_coeff_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient controller:
// FSM state encoding, tap-index width helper and the pass-through default set.
package fir_ctrl_pkg;

    localparam int FIR_TAPS   = 21;
    localparam int COEFF_W    = 8;
    localparam int COEFF_FRAC = 7;

    function automatic int tap_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAP_IDX_W = tap_idx_w(FIR_TAPS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_ARMED     = 2'd2,
        ST_SWAP_WAIT = 2'd3
    } state_t;

    // Centre tap just below unity, all others zero: the FIR acts as a pure delay.
    function automatic int default_coeff(input int tap, input int fir_len, input int frac_bits);
        return (tap == (fir_len - 1) / 2) ? ((1 << frac_bits) - 1) : 0;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// One coefficient set: FIR_LEN x NB_COEFF registers, single indexed write port,
// flat read bus. Resets either to the pass-through set or to all zeros.
module fir_coeff_bank
    import fir_ctrl_pkg::*;
#(
    parameter int FIR_LEN     = FIR_TAPS,
    parameter int NB_COEFF    = COEFF_W,
    parameter int NBF_COEFF   = COEFF_FRAC,
    parameter bit RST_DEFAULT = 1'b1,
    localparam int IDX_W      = tap_idx_w(FIR_LEN)
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_we,
    input  logic [IDX_W-1:0]              i_idx,
    input  logic signed [NB_COEFF-1:0]    i_data,
    output logic [FIR_LEN*NB_COEFF-1:0]   o_coeff
);

    logic signed [NB_COEFF-1:0] mem_q [FIR_LEN];
    logic signed [NB_COEFF-1:0] mem_d [FIR_LEN];

    function automatic logic signed [NB_COEFF-1:0] reset_value(input int k);
        if (RST_DEFAULT) begin
            return NB_COEFF'(default_coeff(k, FIR_LEN, NBF_COEFF));
        end
        return '0;
    endfunction

    always_comb begin
        for (int k = 0; k < FIR_LEN; k++) begin
            mem_d[k] = mem_q[k];
            if (i_we && (i_idx == IDX_W'(k))) begin
                mem_d[k] = i_data;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int k = 0; k < FIR_LEN; k++) begin
                mem_q[k] <= reset_value(k);
            end
        end else begin
            for (int k = 0; k < FIR_LEN; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    always_comb begin
        o_coeff = '0;
        for (int k = 0; k < FIR_LEN; k++) begin
            o_coeff[k*NB_COEFF +: NB_COEFF] = mem_q[k];
        end
    end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Double-buffered coefficient controller: streams a set into the shadow bank and
// swaps it in at a sample boundary by toggling a one-bit bank select.
module fir_coeff_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int FIR_LEN   = FIR_TAPS,
    parameter int NB_COEFF  = COEFF_W,
    parameter int NBF_COEFF = COEFF_FRAC
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_cfg_valid,
    output logic                          o_cfg_ready,
    input  logic signed [NB_COEFF-1:0]    i_cfg_data,
    input  logic                          i_cfg_last,
    input  logic                          i_commit,
    input  logic                          i_sample_valid,
    output logic [FIR_LEN*NB_COEFF-1:0]   o_coeff,
    output logic                          o_armed,
    output logic                          o_swap_done,
    output logic                          o_err
);

    localparam int IDX_W = tap_idx_w(FIR_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIR_LEN - 1);

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          sel_q, sel_d;
    logic [FIR_LEN*NB_COEFF-1:0]   coeff_q, coeff_d;
    logic                          armed_q, armed_d;
    logic                          ready_q, ready_d;
    logic                          swap_done_q, swap_done_d;
    logic                          err_q, err_d;

    logic                          accept;
    logic                          wr_en;
    logic [IDX_W-1:0]              wr_idx;
    logic [FIR_LEN*NB_COEFF-1:0]   bank0_rd, bank1_rd;

    function automatic logic [FIR_LEN*NB_COEFF-1:0] default_set();
        logic [FIR_LEN*NB_COEFF-1:0] v;
        v = '0;
        for (int k = 0; k < FIR_LEN; k++) begin
            v[k*NB_COEFF +: NB_COEFF] = NB_COEFF'(default_coeff(k, FIR_LEN, NBF_COEFF));
        end
        return v;
    endfunction

    assign accept = i_cfg_valid && ready_q;

    // Bank 0 starts as the active (pass-through) set, bank 1 as the empty shadow.
    fir_coeff_bank #(
        .FIR_LEN     (FIR_LEN),
        .NB_COEFF    (NB_COEFF),
        .NBF_COEFF   (NBF_COEFF),
        .RST_DEFAULT (1'b1)
    ) u_bank0 (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_we    (wr_en && sel_q),
        .i_idx   (wr_idx),
        .i_data  (i_cfg_data),
        .o_coeff (bank0_rd)
    );

    fir_coeff_bank #(
        .FIR_LEN     (FIR_LEN),
        .NB_COEFF    (NB_COEFF),
        .NBF_COEFF   (NBF_COEFF),
        .RST_DEFAULT (1'b0)
    ) u_bank1 (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_we    (wr_en && !sel_q),
        .i_idx   (wr_idx),
        .i_data  (i_cfg_data),
        .o_coeff (bank1_rd)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sel_d       = sel_q;
        wr_en       = 1'b0;
        wr_idx      = idx_q;
        err_d       = 1'b0;
        swap_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    idx_d  = IDX_W'(1);
                    if (FIR_LEN == 1) begin
                        idx_d = '0;
                        if (i_cfg_last) state_d = ST_ARMED;
                        else            err_d   = 1'b1;
                    end else if (i_cfg_last) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                    // Both short and long sets collapse to the same error path.
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (i_cfg_last) begin
                            state_d = ST_ARMED;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (i_cfg_last) begin
                        idx_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ARMED: begin
                if (i_commit) state_d = ST_SWAP_WAIT;
            end
            ST_SWAP_WAIT: begin
                if (i_sample_valid) begin
                    sel_d       = ~sel_q;
                    swap_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        armed_d = (state_d == ST_ARMED) || (state_d == ST_SWAP_WAIT);
        ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        // Mux on the next select so the new set appears on the cycle after the swap edge.
        coeff_d = sel_d ? bank1_rd : bank0_rd;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            sel_q       <= 1'b0;
            coeff_q     <= default_set();
            armed_q     <= 1'b0;
            ready_q     <= 1'b1;
            swap_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            coeff_q     <= coeff_d;
            armed_q     <= armed_d;
            ready_q     <= ready_d;
            swap_done_q <= swap_done_d;
            err_q       <= err_d;
        end
    end

    assign o_cfg_ready = ready_q;
    assign o_coeff     = coeff_q;
    assign o_armed     = armed_q;
    assign o_swap_done = swap_done_q;
    assign o_err       = err_q;

endmodule
